// File: rtl/hd_program_loader_pkg.sv
// hd_program_loader_pkg: shared state encoding, default sizes and the header offset for the HD program loader
package hd_program_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, LEN, STREAM, CHK, DONE, ERR} state_t;
  localparam int HD_ADDR_W_DEF = 12;
  localparam int SLOT_W_DEF = 8;
  localparam int MAX_WORDS_DEF = 200;
  localparam int HDR_OFFSET = 0;
endpackage

// File: rtl/hd_program_loader_word_counter.sv
// loader_word_counter: read-issue and write counters of a load, with their terminal-count compares
module loader_word_counter #(
  parameter int CW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          rd_inc,
  input  logic          wr_inc,
  input  logic [CW-1:0] len,
  input  logic [CW-1:0] rd_lim,
  output logic [CW-1:0] rcnt,
  output logic [CW-1:0] wcnt,
  output logic          rd_more,
  output logic          rd_data,
  output logic          wr_last
);
  assign rd_more = rcnt < rd_lim;
  assign rd_data = rcnt < len;
  assign wr_last = wcnt == len - CW'(1);
  // count issued reads and completed writes; cleared before every stream
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rcnt <= '0;
      wcnt <= '0;
    end else begin
      rcnt <= clear ? '0 : rd_inc ? rcnt + CW'(1) : rcnt;
      wcnt <= clear ? '0 : wr_inc ? wcnt + CW'(1) : wcnt;
    end
endmodule

// File: rtl/hd_program_loader.sv
// hd_program_loader: copies a length-prefixed program from an HD slot into instruction memory; LOADER_CHECKSUM_EN adds a trailing checksum word
module hd_program_loader
  import hd_program_loader_pkg::*;
#(
  parameter int HD_ADDR_W = HD_ADDR_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [HD_ADDR_W-SLOT_W-1:0] program_id,
  output logic                    hd_rd_en,
  output logic [HD_ADDR_W-1:0]    hd_addr,
  input  logic [31:0]             hd_rdata,
  output logic                    instr_we,
  output logic [31:0]             instr_addr,
  output logic [31:0]             instr_word,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error,
  output logic [31:0]             loaded_len
);
  localparam int CW = SLOT_W + 1;
`ifdef LOADER_CHECKSUM_EN
  localparam int EXTRA = 2;
  localparam state_t LAST = CHK;
`else
  localparam int EXTRA = 1;
  localparam state_t LAST = DONE;
`endif
  state_t state, state_n;
  logic [HD_ADDR_W-SLOT_W-1:0] pid;
  logic [HD_ADDR_W-1:0] base;
  logic [CW-1:0] len, rcnt, wcnt;
  logic rd_more, rd_data, wr_last, len_ok;
  assign base = {pid, {SLOT_W{1'b0}}};
  assign len_ok = hd_rdata != '0 && hd_rdata <= 32'(MAX_WORDS) && {1'b0, hd_rdata} + 33'(EXTRA) <= 33'(2 ** SLOT_W);
  assign busy = state != IDLE;
  assign load_done = state == DONE;
  assign load_error = state == ERR;
  assign instr_addr = 32'(wcnt);
  assign instr_word = instr_we ? hd_rdata : '0;
  loader_word_counter #(.CW(CW)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clear(state == LEN),
    .rd_inc(hd_rd_en && state == STREAM),
    .wr_inc(instr_we),
    .len(len),
    .rd_lim(len + CW'(EXTRA - 1)),
    .rcnt(rcnt),
    .wcnt(wcnt),
    .rd_more(rd_more),
    .rd_data(rd_data),
    .wr_last(wr_last)
  );
  // state register; reset aborts any load in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // slot latch, length, write strobe (one cycle behind each data read) and last good length
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pid <= '0;
      len <= '0;
      instr_we <= 1'b0;
      loaded_len <= '0;
    end else begin
      pid <= state == IDLE && start ? program_id : pid;
      len <= state == LEN ? CW'(hd_rdata) : len;
      instr_we <= state == STREAM && rd_data;
      loaded_len <= state_n == DONE ? 32'(len) : loaded_len;
    end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  // wrap-around sum of the words written during this load
  always_ff @(posedge clock or posedge reset)
    if (reset) sum <= '0;
    else sum <= state == LEN ? '0 : instr_we ? sum + hd_rdata : sum;
`endif
  // next state and HD read requests
  always_comb begin
    state_n = state;
    hd_rd_en = 1'b0;
    hd_addr = '0;
    case (state)
      IDLE: state_n = start ? HDR : IDLE;
      HDR: begin
        hd_rd_en = 1'b1;
        hd_addr = base + HD_ADDR_W'(HDR_OFFSET);
        state_n = LEN;
      end
      LEN: state_n = len_ok ? STREAM : ERR;
      STREAM: begin
        hd_rd_en = rd_more;
        hd_addr = rd_more ? base + HD_ADDR_W'(rcnt) + HD_ADDR_W'(1) : '0;
        state_n = instr_we && wr_last ? LAST : STREAM;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: state_n = hd_rdata == sum ? DONE : ERR;
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hd_program_loader.sv
// tb_hd_program_loader: randomized self-checking bench with a cycle-level reference model of the loader
module tb_hd_program_loader;
  localparam int AW = 12, SW = 8, MW = 200;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clock = 0, reset = 1, start = 0;
  logic [3:0] program_id = 0;
  logic hd_rd_en, instr_we, busy, load_done, load_error;
  logic [AW-1:0] hd_addr;
  logic [31:0] hd_rdata = 0, instr_addr, instr_word, loaded_len;
  logic [31:0] mem [0:4095];
  logic [31:0] preset [$];
  logic [31:0] exp_len = 0;
  int n_checks = 0, n_fail = 0;

  hd_program_loader dut (
    .clock(clock), .reset(reset), .start(start), .program_id(program_id),
    .hd_rd_en(hd_rd_en), .hd_addr(hd_addr), .hd_rdata(hd_rdata),
    .instr_we(instr_we), .instr_addr(instr_addr), .instr_word(instr_word),
    .busy(busy), .load_done(load_done), .load_error(load_error), .loaded_len(loaded_len)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (hd_rd_en) hd_rdata <= mem[hd_addr];

  task automatic check_idle_zero(input string tag);
    n_checks++;
    if ({busy, hd_rd_en, instr_we, load_done, load_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s ctrl got %b exp 00000", tag, {busy, hd_rd_en, instr_we, load_done, load_error});
    end
    n_checks++;
    if ({hd_addr, instr_addr, instr_word, loaded_len} !== '0) begin
      n_fail++;
      $display("FAIL %s data got hd_addr=%0h instr_addr=%0h instr_word=%0h loaded_len=%0d exp 0", tag, hd_addr, instr_addr, instr_word, loaded_len);
    end
  endtask

  // Caller is at posedge+1 with the DUT idle; this cycle becomes cycle 0.
  task automatic run_load(input int pid, input int n, input bit bad_sum, input int sp, input int abort_c);
    logic [31:0] w [$];
    logic [31:0] s;
    int base, end_c, e_addr;
    bit ok, succ, e_rd, e_we;
    logic [31:0] e_len;
    base = pid << SW;
    ok = n >= 1 && n <= MW && n + 1 + CK <= (1 << SW);
    mem[base] = n;
    s = 0;
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w.push_back(i < preset.size() ? preset[i] : $urandom);
        mem[base + 1 + i] = w[i];
        s += w[i];
      end
      if (CK == 1) mem[base + n + 1] = bad_sum ? s ^ 32'h1 : s;
    end
    succ = ok && !(CK == 1 && bad_sum);
    end_c = !ok ? 3 : n + 4 + CK;
    program_id = 4'(pid);
    start = 1;
    for (int c = 1; c <= end_c + 1; c++) begin
      @(posedge clock); #1;
      start = (c == sp);
      if (c == abort_c) begin
        reset = 1;
        #1;
        check_idle_zero("abort_same_cycle");
        repeat (3) begin
          @(posedge clock); #1;
          n_checks++;
          if ({hd_rd_en, instr_we, load_done, load_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_quiet got %b exp 0000", {hd_rd_en, instr_we, load_done, load_error});
          end
        end
        reset = 0;
        start = 0;
        exp_len = 0;
        return;
      end
      e_rd = c == 1 || (ok && c >= 3 && c <= n + 2 + CK);
      e_addr = c == 1 ? base : base + c - 2;
      e_we = ok && c >= 4 && c <= n + 3;
      e_len = (succ && c >= end_c) ? 32'(n) : exp_len;
      n_checks++;
      if (hd_rd_en !== e_rd) begin
        n_fail++;
        $display("FAIL rd_en n=%0d c=%0d got %b exp %b", n, c, hd_rd_en, e_rd);
      end
      if (e_rd) begin
        n_checks++;
        if (hd_addr !== AW'(e_addr)) begin
          n_fail++;
          $display("FAIL hd_addr n=%0d c=%0d got %0d exp %0d", n, c, hd_addr, e_addr);
        end
      end
      n_checks++;
      if (instr_we !== e_we) begin
        n_fail++;
        $display("FAIL instr_we n=%0d c=%0d got %b exp %b", n, c, instr_we, e_we);
      end
      if (e_we) begin
        n_checks++;
        if (instr_addr !== 32'(c - 4) || instr_word !== w[c - 4]) begin
          n_fail++;
          $display("FAIL write n=%0d c=%0d got addr %0d word %h exp addr %0d word %h", n, c, instr_addr, instr_word, c - 4, w[c - 4]);
        end
      end
      n_checks++;
      if (load_done !== (c == end_c && succ) || load_error !== (c == end_c && !succ)) begin
        n_fail++;
        $display("FAIL done_err n=%0d c=%0d got %b%b exp %b%b", n, c, load_done, load_error, c == end_c && succ, c == end_c && !succ);
      end
      n_checks++;
      if (busy !== (c <= end_c)) begin
        n_fail++;
        $display("FAIL busy n=%0d c=%0d got %b exp %b", n, c, busy, c <= end_c);
      end
      n_checks++;
      if (loaded_len !== e_len) begin
        n_fail++;
        $display("FAIL loaded_len n=%0d c=%0d got %0d exp %0d", n, c, loaded_len, e_len);
      end
    end
    if (succ) exp_len = n;
    start = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    start = 1;
    repeat (2) @(posedge clock);
    #1;
    check_idle_zero("reset_hold");
    start = 0;
    reset = 0;
    @(posedge clock); #1;
    check_idle_zero("after_reset");
  endtask

  task automatic test_basic;
    preset = '{32'hA, 32'hB, 32'hC};
    run_load(1, 3, 0, -1, -1);
    preset.delete();
  endtask

  task automatic test_bad_len;
    run_load(2, 0, 0, -1, -1);
    run_load(3, 201, 0, -1, -1);
  endtask

  task automatic test_start_ignored;
    run_load(4, 5, 0, 2, -1);
  endtask

  task automatic test_reset_abort;
    run_load(5, 10, 0, -1, 5);
    run_load(5, 4, 0, -1, -1);
  endtask

  task automatic test_checksum;
`ifdef LOADER_CHECKSUM_EN
    preset = '{32'hFFFF_FFFF, 32'h2};
    run_load(6, 2, 0, -1, -1);
    run_load(6, 2, 1, -1, -1);
    preset.delete();
`endif
  endtask

  task automatic test_back_to_back;
    run_load(7, 1, 0, -1, -1);
    run_load(8, 2, 0, -1, -1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++) begin
      int n;
      n = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MW + 1, 300)) : $urandom_range(1, 24);
      run_load($urandom_range(1, 15), n, $urandom_range(0, 1) == 1, -1, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    test_reset;
    test_basic;
    test_bad_len;
    test_start_ignored;
    test_reset_abort;
    test_checksum;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hd_program_loader.md
HD_PROGRAM_LOADER -- requirements
Module: hd_program_loader

Interface
REQ-001 Parameter HD_ADDR_W, default 12, width of the HD word address.
REQ-002 Parameter SLOT_W, default 8, log2 of words per program slot on HD; slot base = program_id << SLOT_W.
REQ-003 Parameter MAX_WORDS, default 200, largest accepted program length in words.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle load request (lfhd); sampled only in IDLE.
REQ-007 program_id  input  HD_ADDR_W-SLOT_W  HD slot to load.
REQ-008 hd_rd_en  output  1  HD read strobe; data returns on hd_rdata exactly one cycle later.
REQ-009 hd_addr  output  HD_ADDR_W  HD word address, valid while hd_rd_en=1.
REQ-010 hd_rdata  input  32  HD read data.
REQ-011 instr_we  output  1  write strobe toward instruction memory, one word per asserted cycle.
REQ-012 instr_addr  output  32  instruction-memory write address.
REQ-013 instr_word  output  32  instruction word to write.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 load_done  output  1  one-cycle pulse on successful completion.
REQ-016 load_error  output  1  one-cycle pulse on rejected or failed load.
REQ-017 loaded_len  output  32  length of the last successful load; held until the next success.

Function
REQ-018 States SHALL be IDLE, HDR, LEN, STREAM, CHK, DONE and ERR; DONE and ERR last one cycle each and return to IDLE.
REQ-019 IDLE with start=1 (cycle 0): latch program_id and go to HDR; start outside IDLE SHALL be ignored.
REQ-020 HDR (cycle 1): hd_rd_en=1 with hd_addr=slot base; the word at slot base is the length header N.
REQ-021 LEN (cycle 2): N arrives on hd_rdata; N=0 or N>MAX_WORDS, or N+1 (N+2 with checksum) exceeding 2^SLOT_W, SHALL go to ERR with no instr_we; otherwise go to STREAM.
REQ-022 STREAM: issue reads at base+1 through base+N, one per cycle starting at cycle 3; each return drives instr_we=1 the following cycle with instr_word=hd_rdata.
REQ-023 instr_addr SHALL be 0 for the first word and increment by 1 per write; the last write (address N-1) occurs in cycle N+3.
REQ-024 Without checksum, DONE SHALL occur in cycle N+4 with load_done=1 and loaded_len=N.
REQ-025 hd_rd_en SHALL never be asserted outside HDR, STREAM and the checksum read, and never for an address beyond base+N (+1 with checksum).
REQ-026 Address arithmetic SHALL be unsigned HD_ADDR_W-bit; reads never cross into the next slot because of REQ-021.
REQ-027 instr_we, load_done and load_error SHALL be mutually exclusive in every cycle.

Reset
REQ-028 Reset SHALL force IDLE, busy=0, hd_rd_en=0, instr_we=0, load_done=0, load_error=0, hd_addr=0, instr_addr=0, instr_word=0 and loaded_len=0.
REQ-029 Reset during any load SHALL abort it immediately; no further instr_we or HD read occurs and no done or error pulse is emitted.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, one extra read at base+N+1 returns a checksum; CHK compares it with the 32-bit wrap-around sum of the N program words, and a match gives DONE in cycle N+5 while a mismatch gives ERR in cycle N+5.
REQ-031 Without LOADER_CHECKSUM_EN, the CHK state, the extra read and the accumulator SHALL be absent.

Structure
REQ-032 The shared package SHALL hold the state encoding typedef, the default values of HD_ADDR_W, SLOT_W and MAX_WORDS, and the header offset constant (0).
REQ-033 One sub-module, loader_word_counter, SHALL hold the read-issue and write-count counters together with the terminal-count compare; the FSM stays in the top module.

Verification
REQ-034 Slot 1 with N=3, words A,B,C, no checksum -> hd_addr 256,257,258,259 in cycles 1,3,4,5; instr_we cycles 4-6 at addresses 0-2; load_done in cycle 7; loaded_len=3.
REQ-035 Header N=0, then N=201 -> load_error in cycle 3 and zero instr_we in both cases.
REQ-036 start pulsed in cycle 2 of an N=5 load -> ignored; exactly 5 writes and a single load_done.
REQ-037 Reset asserted in cycle 5 of an N=10 load -> all outputs 0 in the same cycle; no further writes; the next start loads normally from address 0.
REQ-038 LOADER_CHECKSUM_EN with N=2, words 0xFFFFFFFF and 0x2, checksum 0x1 -> load_done in cycle 7; the same load with checksum 0x0 -> load_error in cycle 7.
REQ-039 Back-to-back loads with N=1 then N=2 -> second load's writes start at instr_addr 0; loaded_len changes 1 then 2.
